// File: rtl/afe_ro_buf_addrgen.sv
// AFE readout feeder: sample stream -> word writes into a circular L2 buffer.
// Optional watermark event enabled by defining AFE_RO_WMARK_EN.
module afe_ro_buf_addrgen #(
  parameter int unsigned L2_DATA_WIDTH  = 32,
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned SAMPLE_WIDTH   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_base_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_size_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_wmark_i,
  input  logic                      sample_valid_i,
  output logic                      sample_ready_o,
  input  logic [SAMPLE_WIDTH-1:0]   sample_data_i,
  output logic                      afero_valid_o,
  input  logic                      afero_buff_ce_i,
  output logic [L2_DATA_WIDTH-1:0]  afero_wdata_o,
  output logic [L2_AWIDTH_NOAL-1:0] afero_addr_o,
  output logic [1:0]                afero_size_o,
  output logic                      evt_wrap_o,
  output logic                      evt_wmark_o,
  output logic                      busy_o
);

  localparam int unsigned DW = L2_DATA_WIDTH;
  localparam int unsigned AW = L2_AWIDTH_NOAL;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } stg_t;

  stg_t          stg_q;
  logic          stg_valid;
  logic [AW-1:0] wptr;
  logic [AW-1:0] wptr_inc;
  logic          last_word;
  logic          accept;
  logic          handoff;

  assign wptr_inc  = wptr + AW'(4);
  assign last_word = (wptr_inc == cfg_size_i);

  // clr blocks accepts so the restarted buffer begins cleanly at offset 0
  assign sample_ready_o = cfg_en_i & ~cfg_clr_i
                        & (~stg_valid | afero_buff_ce_i);
  assign accept  = sample_valid_i & sample_ready_o;
  assign handoff = afero_buff_ce_i & stg_valid;

  assign afero_valid_o = stg_valid;
  assign busy_o        = stg_valid;
  assign afero_size_o  = 2'b10;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_valid     <= 1'b0;
      stg_q         <= '0;
      wptr          <= '0;
      afero_wdata_o <= '0;
      afero_addr_o  <= '0;
      evt_wrap_o    <= 1'b0;
    end else begin
      if (cfg_clr_i)
        wptr <= '0;
      else if (accept)
        wptr <= last_word ? '0 : wptr_inc;

      if (accept)
        stg_valid <= 1'b1;
      else if (cfg_clr_i | handoff)
        stg_valid <= 1'b0;

      if (accept) begin
        stg_q.data <= DW'(sample_data_i);
        stg_q.addr <= cfg_base_i + wptr;
      end

      // handoff wins over clr: a committed word always reaches the outputs
      if (handoff) begin
        afero_wdata_o <= stg_q.data;
        afero_addr_o  <= stg_q.addr;
      end

      evt_wrap_o <= accept & last_word;
    end
  end

`ifdef AFE_RO_WMARK_EN
  logic evt_wmark_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      evt_wmark_q <= 1'b0;
    else
      evt_wmark_q <= accept & (wptr == cfg_wmark_i);
  end

  assign evt_wmark_o = evt_wmark_q;
`else
  logic unused_wmark;
  assign unused_wmark = ^cfg_wmark_i;
  assign evt_wmark_o  = 1'b0;
`endif

endmodule

// File: tb/tb_afe_ro_buf_addrgen.sv
// Bench for afe_ro_buf_addrgen: queue-based buffer model + directed vectors.
// Watermark expectations follow AFE_RO_WMARK_EN as compiled.
module tb_afe_ro_buf_addrgen;

`ifdef AFE_RO_WMARK_EN
  localparam bit WM_EN = 1'b1;
`else
  localparam bit WM_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_en_i = 1'b0;
  logic        cfg_clr_i = 1'b0;
  logic [11:0] cfg_base_i = 12'h100;
  logic [11:0] cfg_size_i = 12'h010;
  logic [11:0] cfg_wmark_i = 12'h008;
  logic        sample_valid_i = 1'b0;
  logic        sample_ready_o;
  logic [15:0] sample_data_i = '0;
  logic        afero_valid_o;
  logic        afero_buff_ce_i = 1'b0;
  logic [31:0] afero_wdata_o;
  logic [11:0] afero_addr_o;
  logic [1:0]  afero_size_o;
  logic        evt_wrap_o;
  logic        evt_wmark_o;
  logic        busy_o;

  afe_ro_buf_addrgen dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cfg_en_i       (cfg_en_i),
    .cfg_clr_i      (cfg_clr_i),
    .cfg_base_i     (cfg_base_i),
    .cfg_size_i     (cfg_size_i),
    .cfg_wmark_i    (cfg_wmark_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .sample_data_i  (sample_data_i),
    .afero_valid_o  (afero_valid_o),
    .afero_buff_ce_i(afero_buff_ce_i),
    .afero_wdata_o  (afero_wdata_o),
    .afero_addr_o   (afero_addr_o),
    .afero_size_o   (afero_size_o),
    .evt_wrap_o     (evt_wrap_o),
    .evt_wmark_o    (evt_wmark_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Buffer model: the staging slot is a queue of pending words,
  // the write position is a byte offset taken modulo the buffer size.
  typedef struct {
    logic [31:0] d;
    logic [11:0] a;
  } ent_t;

  ent_t        stg_q[$];
  int          m_off = 0;
  logic [31:0] m_wdata = '0;
  logic [11:0] m_addr = '0;
  bit          m_wrap = 0;
  bit          m_wmark = 0;

  function automatic bit model_ready();
    return cfg_en_i && !cfg_clr_i && (stg_q.size() == 0 || afero_buff_ce_i);
  endfunction

  initial forever begin
    @(posedge clk_i or negedge rst_ni);
    if (!rst_ni) begin
      stg_q.delete();
      m_off = 0; m_wdata = '0; m_addr = '0; m_wrap = 0; m_wmark = 0;
    end else begin
      bit acc;
      acc = sample_valid_i && model_ready();
      m_wrap = 0; m_wmark = 0;
      if (afero_buff_ce_i && stg_q.size() > 0) begin
        m_wdata = stg_q[0].d;
        m_addr  = stg_q[0].a;
        void'(stg_q.pop_front());
      end
      if (cfg_clr_i) begin
        stg_q.delete();
        m_off = 0;
      end
      if (acc) begin
        stg_q.push_back('{d: 32'(sample_data_i),
                          a: 12'((int'(cfg_base_i) + m_off) % 4096)});
        m_wrap  = (m_off + 4 == int'(cfg_size_i));
        m_wmark = WM_EN && (m_off == int'(cfg_wmark_i));
        m_off   = (m_off + 4) % int'(cfg_size_i);
      end
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (rst_ni) begin
      chk("m_valid", afero_valid_o, stg_q.size() != 0);
      chk("m_busy",  busy_o,        stg_q.size() != 0);
      chk("m_ready", sample_ready_o, model_ready());
      chk("m_wdata", afero_wdata_o, m_wdata);
      chk("m_addr",  afero_addr_o,  m_addr);
      chk("m_wrap",  evt_wrap_o,    m_wrap);
      chk("m_wmark", evt_wmark_o,   m_wmark);
      chk("m_size",  afero_size_o,  2'b10);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit ce);
    sample_valid_i  = v;
    sample_data_i   = d;
    afero_buff_ce_i = ce;
  endtask

  logic [11:0] exp_a [5];

  initial begin
    exp_a[0] = 12'h100; exp_a[1] = 12'h104; exp_a[2] = 12'h108;
    exp_a[3] = 12'h10C; exp_a[4] = 12'h100;

    #1;
    chk("rst_valid", afero_valid_o, 1'b0);
    chk("rst_busy",  busy_o,        1'b0);
    chk("rst_addr",  afero_addr_o,  12'h000);
    chk("rst_wdata", afero_wdata_o, 32'h0);
    chk("rst_size",  afero_size_o,  2'b10);
    tick(); tick();
    rst_ni = 1'b1;
    cfg_en_i = 1'b1;
    tick();

    // five words around a 16-byte buffer
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'(i + 1), 0);
      tick();
      chk("t1_wrap", evt_wrap_o, i == 3);
      chk("t1_wmark", evt_wmark_o, WM_EN && i == 2);
      drive(0, 0, 1);
      tick();
      chk("t1_addr", afero_addr_o, exp_a[i]);
      chk("t1_data", afero_wdata_o, 32'(i + 1));
    end
    drive(0, 0, 0);
    tick();

    // buff_ce held high, back-to-back
    drive(1, 16'hA5A5, 1);
    #1 chk("t2_rdy0", sample_ready_o, 1'b1);
    tick();
    drive(1, 16'h1234, 1);
    #1 chk("t2_rdy1", sample_ready_o, 1'b1);
    tick();
    chk("t2_d0", afero_wdata_o, 32'h0000A5A5);
    chk("t2_a0", afero_addr_o, 12'h104);
    drive(0, 0, 1);
    tick();
    chk("t2_d1", afero_wdata_o, 32'h00001234);
    chk("t2_a1", afero_addr_o, 12'h108);
    drive(0, 0, 0);
    tick();

    // downstream stall for three cycles
    drive(1, 16'h0077, 0);
    tick();
    drive(1, 16'h0088, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_stall_rdy", sample_ready_o, 1'b0);
      chk("t3_stall_vld", afero_valid_o, 1'b1);
      tick();
    end
    drive(1, 16'h0088, 1);
    #1 chk("t3_rel_rdy", sample_ready_o, 1'b1);
    tick();
    chk("t3_d77", afero_wdata_o, 32'h77);
    chk("t3_a77", afero_addr_o, 12'h10C);
    chk("t3_vld", afero_valid_o, 1'b1);
    drive(0, 0, 1);
    tick();
    chk("t3_d88", afero_wdata_o, 32'h88);
    chk("t3_a88", afero_addr_o, 12'h100);
    drive(0, 0, 0);
    tick();

    // clr together with buff_ce: committed word survives
    drive(1, 16'h0055, 0);
    tick();
    drive(1, 16'h00EE, 1);
    cfg_clr_i = 1'b1;
    #1 chk("t4_clr_rdy", sample_ready_o, 1'b0);
    tick();
    cfg_clr_i = 1'b0;
    chk("t4_d55", afero_wdata_o, 32'h55);
    chk("t4_a55", afero_addr_o, 12'h104);
    chk("t4_vld", afero_valid_o, 1'b0);
    drive(1, 16'h0066, 0);
    tick();
    drive(0, 0, 1);
    tick();
    chk("t4_a66", afero_addr_o, 12'h100);
    // clr alone drops the staged word
    drive(1, 16'h0099, 0);
    tick();
    drive(0, 0, 0);
    cfg_clr_i = 1'b1;
    tick();
    cfg_clr_i = 1'b0;
    chk("t4_drop_vld", afero_valid_o, 1'b0);
    chk("t4_drop_d", afero_wdata_o, 32'h66);
    drive(1, 16'h00AB, 0);
    tick();
    drive(0, 0, 1);
    tick();
    chk("t4_aAB", afero_addr_o, 12'h100);
    chk("t4_dAB", afero_wdata_o, 32'hAB);
    drive(0, 0, 0);
    tick();

    // enable low: no accepts, staged word still drains
    drive(1, 16'h00CD, 0);
    tick();
    cfg_en_i = 1'b0;
    #1 chk("t5_rdy", sample_ready_o, 1'b0);
    tick();
    drive(1, 16'h00DD, 1);
    tick();
    chk("t5_dCD", afero_wdata_o, 32'hCD);
    chk("t5_vld", afero_valid_o, 1'b0);
    tick();
    chk("t5_idle", busy_o, 1'b0);
    drive(0, 0, 0);
    cfg_en_i = 1'b1;
    tick();

    // address sum wraps modulo 2^12
    cfg_base_i = 12'hFFC;
    cfg_size_i = 12'h008;
    cfg_clr_i  = 1'b1;
    tick();
    cfg_clr_i = 1'b0;
    drive(1, 16'h0001, 0);
    tick();
    drive(1, 16'h0002, 1);
    tick();
    chk("t6_aFFC", afero_addr_o, 12'hFFC);
    chk("t6_wrap", evt_wrap_o, 1'b1);
    drive(0, 0, 1);
    tick();
    chk("t6_a000", afero_addr_o, 12'h000);
    chk("t6_d2", afero_wdata_o, 32'h2);
    drive(0, 0, 0);
    tick();

    // async reset with a word staged
    drive(1, 16'h0003, 0);
    tick();
    drive(0, 0, 0);
    chk("t7_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("t7_rst_busy", busy_o, 1'b0);
    chk("t7_rst_vld", afero_valid_o, 1'b0);
    chk("t7_rst_addr", afero_addr_o, 12'h000);
    chk("t7_rst_data", afero_wdata_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
